// File: rtl/pusch_scrambler_if.sv
// pusch_scrambler_if: block control, serial bit stream and status of the PUSCH scrambler.
// PUSCH_SCR_BYPASS_EN adds the bypass select, sampled on start.
interface pusch_scrambler_if #(parameter int E_W = 17);
    logic           start;
    logic [30:0]    c_init;
    logic [E_W-1:0] E;
    logic           data_in;
    logic           valid_in;
    logic           data_out;
    logic           valid_out;
    logic           ready;
    logic           done;
    logic           err;
`ifdef PUSCH_SCR_BYPASS_EN
    logic           bypass;
`endif
    modport master (
`ifdef PUSCH_SCR_BYPASS_EN
        output bypass,
`endif
        output start, c_init, E, data_in, valid_in,
        input  data_out, valid_out, ready, done, err
    );
    modport slave (
`ifdef PUSCH_SCR_BYPASS_EN
        input  bypass,
`endif
        input  start, c_init, E, data_in, valid_in,
        output data_out, valid_out, ready, done, err
    );
endinterface

// File: rtl/pusch_scrambler.sv
// pusch_scrambler: XORs the interleaved bit stream with the Gold sequence c(n) seeded by c_init.
// PUSCH_SCR_BYPASS_EN adds a bypass mode that passes bits through with identical timing.
module pusch_scrambler #(
    parameter int NC  = 1600,
    parameter int E_W = 17
) (
    input logic              clk,
    input logic              reset,
    pusch_scrambler_if.slave bus
);
    localparam int WC_W = $clog2(NC + 1);
    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
    state_t         state, state_d;
    logic [30:0]    x1, x2;
    logic [WC_W-1:0] wcnt;
    logic [E_W-1:0] e_q, bit_cnt;
    logic           shift, accept, last, mask;
    logic           data_q, valid_q, done_q, err_q;
    always_comb begin
        state_d = state;
        shift   = 1'b0;
        accept  = 1'b0;
        last    = 1'b0;
        if (bus.start) begin
            state_d = WARMUP;
        end else if (state == WARMUP) begin
            shift   = wcnt != WC_W'(NC);
            state_d = shift ? WARMUP : RUN;
        end else if (state == RUN) begin
            last    = bit_cnt == e_q;
            accept  = bus.valid_in && !last;
            shift   = accept;
            state_d = last ? IDLE : RUN;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end
`ifdef PUSCH_SCR_BYPASS_EN
    logic byp_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         byp_q <= 1'b0;
        else if (bus.start) byp_q <= bus.bypass;
    end
    assign mask = (x1[0] ^ x2[0]) & ~byp_q;
`else
    assign mask = x1[0] ^ x2[0];
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x1      <= '0;
            x2      <= '0;
            wcnt    <= '0;
            e_q     <= '0;
            bit_cnt <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= accept;
            done_q  <= last;
            // a bit presented alongside start is dropped, so it re-arms err
            err_q   <= bus.start ? bus.valid_in : err_q | (bus.valid_in && state != RUN);
            if (accept) data_q <= bus.data_in ^ mask;
            if (bus.start) begin
                x1      <= 31'h1;
                x2      <= bus.c_init;
                wcnt    <= '0;
                e_q     <= bus.E;
                bit_cnt <= '0;
            end else if (shift) begin
                x1 <= {x1[3] ^ x1[0], x1[30:1]};
                x2 <= {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
                if (state == WARMUP) wcnt <= wcnt + WC_W'(1);
                else                 bit_cnt <= bit_cnt + E_W'(1);
            end
        end
    end
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.ready     = state == RUN;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_pusch_scrambler.sv
// tb_pusch_scrambler: scoreboard bench; golden c(n) comes from the x1/x2 recurrences on bit arrays.
module tb_pusch_scrambler;
    localparam int NC = 1600;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    pusch_scrambler_if #(.E_W(17)) bus();
    pusch_scrambler #(.NC(NC), .E_W(17)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {logic d; int t;} exp_t;
    exp_t exp_q[$];
    int checks = 0, passes = 0, cyc = 0, done_cnt = 0, rdy_cnt = 0;
    logic gc [0:127];
    always @(posedge clk) cyc++;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.ready === 1'b1) rdy_cnt++;
        if (bus.valid_out === 1'b1) begin
            check("expected output pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data_out", int'(bus.data_out), int'(e.d));
                check("latency", cyc, e.t);
            end
        end
    end
    task automatic gen(input logic [30:0] ci);
        logic x1s [0:NC+160];
        logic x2s [0:NC+160];
        for (int i = 0; i < 31; i++) begin
            x1s[i] = (i == 0);
            x2s[i] = ci[i];
        end
        for (int n = 0; n < NC + 128; n++) begin
            x1s[n+31] = x1s[n+3] ^ x1s[n];
            x2s[n+31] = x2s[n+3] ^ x2s[n+2] ^ x2s[n+1] ^ x2s[n];
        end
        for (int n = 0; n < 128; n++) gc[n] = x1s[n+NC] ^ x2s[n+NC];
    endtask
    task automatic do_start(input logic [30:0] ci, input int e);
        bus.c_init = ci;
        bus.E = 17'(e);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask
    task automatic wait_ready(input int n0, output int n);
        n = n0;
        while (bus.ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask
    task automatic send(input logic [127:0] pat, input int n, input bit gap, input bit byp);
        for (int i = 0; i < n; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in = pat[i];
            exp_q.push_back('{pat[i] ^ (gc[i] & ~byp), cyc + 1});
            @(posedge clk); #1;
            bus.valid_in = 1'b0;
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask
    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done pulse count", done_cnt - base, 1);
        check("ready low after done", int'(bus.ready), 0);
    endtask
    initial begin
        int n, base, r0;
        bus.start = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in = 1'b0;
        bus.c_init = '0;
        bus.E = '0;
`ifdef PUSCH_SCR_BYPASS_EN
        bus.bypass = 1'b0;
`endif
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", int'(bus.data_out), 0);
        check("reset valid_out", int'(bus.valid_out), 0);
        check("reset ready", int'(bus.ready), 0);
        check("reset done", int'(bus.done), 0);
        check("reset err", int'(bus.err), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        // warm-up timing, err on early bit
        gen(31'h0);
        do_start(31'h0, 16);
        bus.valid_in = 1'b1;
        bus.data_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        check("err in warmup", int'(bus.err), 1);
        wait_ready(1, n);
        check("warmup cycles c_init=0", n, NC + 1);
        base = done_cnt;
        send(128'hBEEF, 16, 1'b0, 1'b0);
        wait_done(base);
        // golden 64-bit sequence, err cleared by start
        gen(31'h1234567);
        do_start(31'h1234567, 64);
        check("err cleared by start", int'(bus.err), 0);
        wait_ready(0, n);
        check("warmup cycles seq", n, NC + 1);
        base = done_cnt;
        send(128'h0, 64, 1'b0, 1'b0);
        wait_done(base);
        // gapless then gapped, same seed and data
        gen(31'h5A5A5A5);
        for (int g = 0; g < 2; g++) begin
            do_start(31'h5A5A5A5, 8);
            wait_ready(0, n);
            check("warmup cycles gaps", n, NC + 1);
            base = done_cnt;
            send(128'hA5, 8, g[0], 1'b0);
            wait_done(base);
        end
        // abort after 10 bits; start collides with a bit
        gen(31'h7000001);
        do_start(31'h7000001, 32);
        wait_ready(0, n);
        send(128'h3C5A, 10, 1'b0, 1'b0);
        base = done_cnt;
        gen(31'h0ABCDEF);
        bus.valid_in = 1'b1;
        do_start(31'h0ABCDEF, 16);
        bus.valid_in = 1'b0;
        check("err start+valid", int'(bus.err), 1);
        wait_ready(0, n);
        check("warmup cycles restart", n, NC + 1);
        check("no done on abort", done_cnt - base, 0);
        send(128'h9F31, 16, 1'b0, 1'b0);
        wait_done(base);
        // E=0
        r0 = rdy_cnt;
        base = done_cnt;
        do_start(31'h13579BD, 0);
        wait_ready(0, n);
        check("warmup cycles E=0", n, NC + 1);
        wait_done(base);
        check("ready cycles E=0", rdy_cnt - r0, 1);
        check("no output E=0", exp_q.size(), 0);
`ifdef PUSCH_SCR_BYPASS_EN
        bus.bypass = 1'b1;
        gen(31'h1);
        do_start(31'h1, 4);
        bus.bypass = 1'b0;
        wait_ready(0, n);
        base = done_cnt;
        send(128'hB, 4, 1'b0, 1'b1);
        wait_done(base);
`endif
        // async reset mid-block
        gen(31'h2468ACE);
        do_start(31'h2468ACE, 16);
        wait_ready(0, n);
        base = done_cnt;
        send(128'hFFFF, 5, 1'b0, 1'b0);
        #6;
        check("valid_out before reset", int'(bus.valid_out), 1);
        reset = 1'b0;
        #1;
        check("mid reset data_out", int'(bus.data_out), 0);
        check("mid reset valid_out", int'(bus.valid_out), 0);
        check("mid reset ready", int'(bus.ready), 0);
        check("mid reset done", int'(bus.done), 0);
        check("mid reset err", int'(bus.err), 0);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("ready stays low after reset", int'(bus.ready), 0);
        check("no done after reset", done_cnt - base, 0);
        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
